// File: rtl/router_outport_fifo.sv
// rtl/router_outport_fifo.sv - per-output-port show-ahead flit FIFO with registered ready (optional status: OUTPORT_FIFO_STATUS_EN)
module router_outport_fifo #(
  parameter int FLIT_W       = 32,
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 2,
  parameter int READY_MARGIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] data_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [FLIT_W-1:0] data_out,
  input  logic              rd_ack,
`ifdef OUTPORT_FIFO_STATUS_EN
  output logic [ADDR_W:0]   occupancy,
  output logic [ADDR_W:0]   peak,
`endif
  output logic              overflow
);

  // Free-slot arithmetic is one bit wider than the pointers so DEPTH itself fits.
  localparam logic [ADDR_W+1:0] DEPTH_W  = DEPTH[ADDR_W+1:0];
  localparam logic [ADDR_W+1:0] MARGIN_W = READY_MARGIN[ADDR_W+1:0];

  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              ready_q, ready_d;
  logic              overflow_q, overflow_d;

  logic              empty, full;
  logic              wr_fire, rd_fire;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W+1:0] free_next;

  // Occupancy flags and next-state pointers, all from the registered pointers.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    // A full buffer rejects writes even when a read frees a slot this cycle.
    wr_fire    = wr_en && !full;
    rd_fire    = rd_ack && !empty;
    wr_ptr_d   = wr_ptr_q + {{ADDR_W{1'b0}}, wr_fire};
    rd_ptr_d   = rd_ptr_q + {{ADDR_W{1'b0}}, rd_fire};
    count_next = wr_ptr_d - rd_ptr_d;
    free_next  = DEPTH_W - {1'b0, count_next};
    // Ready holds back READY_MARGIN slots for flits already launched upstream.
    ready_d    = (free_next > MARGIN_W);
    overflow_d = overflow_q || (wr_en && full);
  end

  // Pointer, ready and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  // Flit storage; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

  assign ready_out = ready_q;
  assign overflow  = overflow_q;
  assign valid_out = !empty;
  assign data_out  = mem_q[rd_ptr_q[ADDR_W-1:0]];

`ifdef OUTPORT_FIFO_STATUS_EN
  logic [ADDR_W:0] peak_q, peak_d;

  // High-water mark tracks the post-update occupancy.
  always_comb begin
    peak_d = (count_next > peak_q) ? count_next : peak_q;
  end

  // Peak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign peak      = peak_q;
`endif

endmodule

// File: doc/router_outport_fifo.md
Name: router_outport_fifo

Overview:
Per-output-port flit buffer on the crossbar side of the router. It stores flits switched to one output direction (L, N or E) and presents them downstream with a show-ahead valid/ack handshake. It generates the registered ready indication (Lready_in / Nready_in / Eready_in) that the flow-control stage gates with the port-select signals before the arbiter sees them. One instance is used per output direction.

Parameters:
FLIT_W, 32, flit width in bits
DEPTH, 4, buffer entries; must be a power of 2, minimum 2
ADDR_W, 2, log2(DEPTH); must be consistent with DEPTH
READY_MARGIN, 1, number of free slots held back to absorb flits already in flight when ready drops

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
wr_en  input  1  crossbar writes data_in this cycle
data_in  input  FLIT_W  flit from crossbar
ready_out  output  1  buffer can accept further flits; feeds the flow-control Xready_in
valid_out  output  1  data_out holds a valid flit
data_out  output  FLIT_W  head flit (show-ahead)
rd_ack  input  1  downstream consumes the head flit this cycle
overflow  output  1  sticky flag: a write arrived while the buffer was full

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, ready_out=0, overflow=0, valid_out=0. Memory contents are not reset.
- Pointers are ADDR_W+1 bits wide.
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
  - Pointers wrap naturally; there is no explicit wrap logic.
- Write:
  - Accepted when wr_en && !full, using full from the current registered state.
  - mem[wr_ptr[ADDR_W-1:0]] <= data_in; wr_ptr increments.
- Read:
  - Accepted when rd_ack && !empty; rd_ptr increments.
  - rd_ack while empty is ignored: no pointer change, no error.
- Output timing:
  - valid_out = !empty.
  - data_out = mem[rd_ptr[ADDR_W-1:0]] (combinational read of registered storage).
  - Latency from an accepted write into an empty buffer to valid_out=1: 1 cycle.
- Simultaneous read and write:
  - Not full: both are performed and count is unchanged.
  - Full: the write is rejected even if a read occurs in the same cycle. There is no full-pass-through.
  - Empty: the write is accepted, the read is ignored, and valid_out rises next cycle.
- Write while full: the flit is dropped, pointers are unchanged, and overflow is set. overflow stays set until reset.
- ready_out (registered):
  - Next value = (DEPTH - count_next) > READY_MARGIN, where count_next is the post-update occupancy for this cycle.
  - After rst deasserts, ready_out rises on the first clock edge.
  - Example with DEPTH=4, READY_MARGIN=1: ready_out=1 when count_next is 0, 1 or 2; ready_out=0 when count_next is 3 or 4.
- Upstream protocol: the crossbar may issue at most READY_MARGIN writes after ready_out falls. Honouring that rule, overflow never sets.
- Reset mid-operation clears everything immediately. valid_out and ready_out drop in the same cycle as rst asserts.

Optional Feature:
OUTPORT_FIFO_STATUS_EN
- Defined: adds output port occupancy [ADDR_W:0] = count (registered pointers, combinational difference) and output port peak [ADDR_W:0].
  - peak is a registered high-water mark of count, reset to 0.
  - peak updates to count_next whenever count_next > peak.
- Undefined: neither port exists, and no peak register is synthesised. All other behaviour is identical.

Test Plan:
- Reset then idle (DEPTH=4, MARGIN=1): hold rst 3 cycles, then release -> ready_out=0 during reset and 1 one edge after release; valid_out=0; overflow=0.
- Fill without reads: write 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles ->
  - ready_out falls on the edge of the 3rd write (count 3).
  - valid_out=1 with data_out=0xA1 one cycle after the first write.
  - overflow stays 0.
- Overflow: with 4 entries stored, write 0xFF -> write dropped, overflow=1 and sticky; drain with 4 rd_ack -> data_out order 0xA1..0xA4, 0xFF never appears.
- Simultaneous read/write:
  - count=2: wr_en+rd_ack every cycle for 10 cycles -> count stays 2, FIFO order preserved, ready_out stays 1.
  - count=4 (full): wr_en+rd_ack -> write rejected, count becomes 3.
- Wrap-around: stream 20 flits with incrementing values 0x00..0x13 while rd_ack is held high -> all received in order, pointers wrap multiple times, valid_out never deasserts after the first flit until the stream ends.
- Reset mid-stream: with count=3, assert rst asynchronously between edges -> valid_out, ready_out and overflow go 0 immediately; after release the buffer is empty and the next write 0x55 appears on data_out one cycle later.
